// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: turns single-beat CPU requests into setup/strobe/hold cycles on one decoded device.
// Build option BUS_CYC_EXT_RDY_EN adds a dev_rdy handshake that stretches STROBE, with a timeout.
module bus_cycle_ctrl #(
    parameter int DW          = 32,
    parameter int SETUP_CYC   = 1,
    parameter int HOLD_CYC    = 1,
    parameter int CE0_WAIT    = 2,
    parameter int CE1_WAIT    = 4,
    parameter int CS_WAIT     = 0,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic [1:0]    dec_addr,
    output logic          dec_en,
    input  logic          dec_ce0,
    input  logic          dec_ce1,
    input  logic          dec_cs,
    output logic          dev_ce0,
    output logic          dev_ce1,
    output logic          dev_cs,
    output logic          dev_oe,
    output logic          dev_we,
    output logic [29:0]   dev_addr,
    output logic [DW-1:0] dev_wdata,
    input  logic [DW-1:0] dev_rdata,
`ifdef BUS_CYC_EXT_RDY_EN
    input  logic          dev_rdy,
`endif
    output logic          resp_valid,
    output logic          resp_err,
    output logic [DW-1:0] resp_rdata
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

`ifdef BUS_CYC_EXT_RDY_EN
    localparam bit EXT_RDY = 1'b1;
    logic rdy;
    assign rdy = dev_rdy;
`else
    localparam bit EXT_RDY = 1'b0;
    logic rdy;
    assign rdy = 1'b1;
`endif
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    wait_q;
    logic [2:0]    sel_q;
    logic          wr_q;
    logic          ready_q;
    logic [DW-1:0] rdata_q;
    logic [29:0]   addr_q;
    logic [DW-1:0] wdata_q;
    logic          ce0_q, ce1_q, cs_q, oe_q, we_q;
    logic          resp_valid_q, resp_err_q;
    logic [DW-1:0] resp_rdata_q;

    logic          accept, capture, dec_ok, active_d, wr_n;
    logic [2:0]    dec_sel, sel_n;
    logic [7:0]    dec_wait;
    logic [DW-1:0] rdata_n;

    assign accept    = req_valid & ready_q;
    assign req_ready = ready_q;
    assign dec_en    = accept;
    assign dec_addr  = req_addr[31:30];
    assign dec_sel   = {dec_ce0, dec_ce1, dec_cs};
    assign dec_ok    = (dec_sel == 3'b100) || (dec_sel == 3'b010) || (dec_sel == 3'b001);

    always_comb begin
        case (dec_sel)
            3'b100:  dec_wait = 8'(CE0_WAIT);
            3'b010:  dec_wait = 8'(CE1_WAIT);
            default: dec_wait = 8'(CS_WAIT);
        endcase
    end

    // STROBE counts up from 0 so the same counter serves fixed waits and the dev_rdy timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 8'd0;
                    err_d = !dec_ok;
                    if (!dec_ok) begin
                        state_d = RESP;
                    end else if (SETUP_CYC != 0) begin
                        state_d = SETUP;
                        cnt_d   = 8'(SETUP_CYC - 1);
                    end else begin
                        state_d = STROBE;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = STROBE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q >= wait_q && rdy) begin
                    capture = 1'b1;
                    state_d = (HOLD_CYC != 0) ? HOLD : RESP;
                    cnt_d   = 8'(HOLD_CYC - 1);
                end else if (EXT_RDY && cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = (HOLD_CYC != 0) ? HOLD : RESP;
                    cnt_d   = 8'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so pins line up with the phase they belong to.
    assign sel_n    = accept ? dec_sel : sel_q;
    assign wr_n     = accept ? req_wr : wr_q;
    assign rdata_n  = capture ? dev_rdata : rdata_q;
    assign active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            err_q        <= 1'b0;
            wait_q       <= 8'd0;
            sel_q        <= 3'b000;
            wr_q         <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ce0_q        <= 1'b0;
            ce1_q        <= 1'b0;
            cs_q         <= 1'b0;
            oe_q         <= 1'b0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                sel_q   <= dec_sel;
                wr_q    <= req_wr;
                wait_q  <= dec_wait;
                addr_q  <= req_addr[29:0];
                wdata_q <= req_wdata;
            end
            if (capture) begin
                rdata_q <= dev_rdata;
            end
            {ce0_q, ce1_q, cs_q} <= active_d ? sel_n : 3'b000;
            oe_q         <= (state_d == STROBE) && !wr_n;
            we_q         <= (state_d == STROBE) && wr_n;
            resp_valid_q <= (state_d == RESP);
            resp_err_q   <= (state_d == RESP) && err_d;
            resp_rdata_q <= ((state_d == RESP) && !err_d && !wr_n) ? rdata_n : '0;
        end
    end

    assign dev_ce0    = ce0_q;
    assign dev_ce1    = ce1_q;
    assign dev_cs     = cs_q;
    assign dev_oe     = oe_q;
    assign dev_we     = we_q;
    assign dev_addr   = addr_q;
    assign dev_wdata  = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: default-timing instance and a zero-setup/zero-hold instance,
// driven with directed and random requests, checked against a phase-arithmetic model.
module tb_bus_cycle_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_wr    [2];
    logic [31:0]   req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [1:0]    dec_addr  [2];
    logic          dec_en    [2];
    logic          dec_ce0   [2];
    logic          dec_ce1   [2];
    logic          dec_cs    [2];
    logic          dev_ce0   [2];
    logic          dev_ce1   [2];
    logic          dev_cs    [2];
    logic          dev_oe    [2];
    logic          dev_we    [2];
    logic [29:0]   dev_addr  [2];
    logic [DW-1:0] dev_wdata [2];
    logic [DW-1:0] dev_rdata [2];
    logic          resp_valid[2];
    logic          resp_err  [2];
    logic [DW-1:0] resp_rdata[2];
    int            fault_mode[2];

    logic [29:0]   last_addr [2];
    logic [31:0]   last_wdata[2];

    int total = 0;
    int bad   = 0;

    bus_cycle_ctrl u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .dec_addr(dec_addr[0]), .dec_en(dec_en[0]),
        .dec_ce0(dec_ce0[0]), .dec_ce1(dec_ce1[0]), .dec_cs(dec_cs[0]),
        .dev_ce0(dev_ce0[0]), .dev_ce1(dev_ce1[0]), .dev_cs(dev_cs[0]),
        .dev_oe(dev_oe[0]), .dev_we(dev_we[0]),
        .dev_addr(dev_addr[0]), .dev_wdata(dev_wdata[0]), .dev_rdata(dev_rdata[0]),
        .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .resp_rdata(resp_rdata[0])
    );

    bus_cycle_ctrl #(
        .SETUP_CYC(0), .HOLD_CYC(0), .CE0_WAIT(1), .CE1_WAIT(3), .CS_WAIT(0)
    ) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .dec_addr(dec_addr[1]), .dec_en(dec_en[1]),
        .dec_ce0(dec_ce0[1]), .dec_ce1(dec_ce1[1]), .dec_cs(dec_cs[1]),
        .dev_ce0(dev_ce0[1]), .dev_ce1(dev_ce1[1]), .dev_cs(dev_cs[1]),
        .dev_oe(dev_oe[1]), .dev_we(dev_we[1]),
        .dev_addr(dev_addr[1]), .dev_wdata(dev_wdata[1]), .dev_rdata(dev_rdata[1]),
        .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .resp_rdata(resp_rdata[1])
    );

    // Behavioural decoder; fault_mode 1 forces no select, 2 forces ce0+cs together.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            dec_ce0[g] = 1'b0;
            dec_ce1[g] = 1'b0;
            dec_cs[g]  = 1'b0;
            if (fault_mode[g] == 2) begin
                dec_ce0[g] = 1'b1;
                dec_cs[g]  = 1'b1;
            end else if (fault_mode[g] == 0 && dec_en[g]) begin
                dec_ce0[g] = (dec_addr[g] == 2'b10);
                dec_ce1[g] = (dec_addr[g] == 2'b11);
                dec_cs[g]  = (dec_addr[g][1] == 1'b0);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_of(input int i);
        return {dev_ce0[i], dev_ce1[i], dev_cs[i], dev_oe[i], dev_we[i],
                resp_valid[i], resp_err[i], req_ready[i]};
    endfunction

    function automatic int setup_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int wait_of(input int i, input logic [2:0] sel);
        if (sel == 3'b100) return (i == 0) ? 2 : 1;
        if (sel == 3'b010) return (i == 0) ? 4 : 3;
        return 0;
    endfunction

    // Entered and left at #1 after a rising edge; the entry cycle is the accept cycle T0.
    task automatic run_txn(input int i, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int fault);
        logic [2:0]  sel;
        logic [31:0] rd [64];
        logic [7:0]  exp;
        logic [31:0] exp_rd;
        bit          err;
        int          s, w, h, l;

        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        fault_mode[i] = fault;
        dev_rdata[i] = $urandom;
        @(negedge clk);
        check_eq($sformatf("t0_ctrl_i%0d", i), 64'(ctrl_of(i)), 64'h01);
        check_eq($sformatf("t0_dev_hold_i%0d", i), {2'b0, dev_addr[i], dev_wdata[i]},
                 {2'b0, last_addr[i], last_wdata[i]});
        check_eq($sformatf("t0_dec_i%0d", i), 64'({dec_en[i], dec_addr[i]}), 64'({1'b1, addr[31:30]}));
        @(posedge clk); #1;
        req_valid[i]  = 1'b0;
        req_addr[i]   = $urandom;
        req_wdata[i]  = $urandom;
        req_wr[i]     = 1'($urandom);
        fault_mode[i] = 0;
        last_addr[i]  = addr[29:0];
        last_wdata[i] = wd;

        if (fault == 1)               sel = 3'b000;
        else if (fault == 2)          sel = 3'b101;
        else if (addr[31:30] == 2'b10) sel = 3'b100;
        else if (addr[31:30] == 2'b11) sel = 3'b010;
        else                          sel = 3'b001;
        err = !(sel == 3'b100 || sel == 3'b010 || sel == 3'b001);
        s = setup_of(i);
        h = hold_of(i);
        w = wait_of(i, sel);
        l = err ? 1 : s + (w + 1) + h + 1;

        for (int k = 1; k <= l; k++) begin
            rd[k] = $urandom;
            dev_rdata[i] = rd[k];
            @(negedge clk);
            exp = 8'h00;
            if (k == l) begin
                exp[2] = 1'b1;
                exp[1] = err;
            end else begin
                exp[7:5] = sel;
                exp[4] = !wr && k > s && k <= s + w + 1;
                exp[3] = wr && k > s && k <= s + w + 1;
            end
            check_eq($sformatf("ctrl_i%0d_k%0d", i, k), 64'(ctrl_of(i)), 64'(exp));
            if (k == l) begin
                exp_rd = (err || wr) ? 32'h0 : rd[s + w + 1];
                check_eq($sformatf("rdata_i%0d", i), 64'(resp_rdata[i]), 64'(exp_rd));
            end
            if (k == 1) begin
                check_eq($sformatf("dev_latch_i%0d", i), {2'b0, dev_addr[i], dev_wdata[i]},
                         {2'b0, addr[29:0], wd});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_mid_strobe();
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b1;
        req_addr[0]  = 32'hC000_0008;
        req_wdata[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_pre_strobe", 64'(ctrl_of(0)), 64'(8'b010_01_000));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_ctrl", 64'(ctrl_of(0)), 64'h00);
        check_eq("rst_addr", 64'(dev_addr[0]), 64'h0);
        check_eq("rst_wdata", 64'(dev_wdata[0]), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_%0d", j), 64'(ctrl_of(0)), (j == 0) ? 64'h00 : 64'h01);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            last_addr[i]  = '0;
            last_wdata[i] = '0;
        end
    endtask

    initial begin
        int i, gap, r, fault;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req_valid[g]  = 1'b0;
            req_wr[g]     = 1'b0;
            req_addr[g]   = '0;
            req_wdata[g]  = '0;
            dev_rdata[g]  = '0;
            fault_mode[g] = 0;
            last_addr[g]  = '0;
            last_wdata[g] = '0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("reset_ctrl0", 64'(ctrl_of(0)), 64'h00);
        check_eq("reset_ctrl1", 64'(ctrl_of(1)), 64'h00);
        check_eq("reset_rdata0", 64'(resp_rdata[0]), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(0, 1'b0, 32'h8000_0010, 32'h0, 0);
        run_txn(0, 1'b1, 32'hC000_0004, 32'h1234_5678, 0);
        run_txn(0, 1'b0, 32'h4000_0100, 32'h0, 1);
        run_txn(0, 1'b1, 32'h8000_0200, 32'h5555_AAAA, 2);
        run_txn(0, 1'b0, 32'h0000_0040, 32'h0, 0);
        reset_mid_strobe();
        run_txn(0, 1'b1, 32'hC000_0010, 32'hCAFE_F00D, 0);
        run_txn(1, 1'b0, 32'h0000_0000, 32'h0, 0);
        run_txn(1, 1'b1, 32'h8000_0008, 32'h0BAD_F00D, 0);
        run_txn(1, 1'b0, 32'hC000_0030, 32'h0, 1);

        for (int n = 0; n < 80; n++) begin
            i   = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 2));
            r   = int'($urandom_range(0, 9));
            fault = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            run_txn(i, 1'($urandom), $urandom, $urandom, fault);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
